con_ff_unit: RTL

CON_FF_UNIT -- requirements
Module: con_ff_unit

---
 rtl/con_ff_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/con_ff_unit.sv
// Conditional flip-flop unit: captures an operand and a 3-bit condition, derives z/n flags,
// then registers the branch-taken result. Optional outcome history via CON_FF_UNIT_HISTORY_EN.
module con_ff_unit #(
  parameter int DATA_W   = 32,
  parameter int COND_LSB = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       ir,
  input  logic [DATA_W-1:0] bus_contents,
  input  logic              con_in,
  input  logic              clr_err,
  output logic              q,
  output logic              q_valid,
  output logic              busy,
  output logic              err,
  output logic [7:0]        hist
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    EVAL = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] opnd;
  logic [2:0]        cond;
  logic              z;
  logic              n;
  logic              cond_true;
  logic              drop;

  // Only the condition field of ir matters; the rest is deliberately ignored.
  logic unused_ir;
  assign unused_ir = ^ir;

  assign drop = con_in && (state != IDLE);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000:  cond_true = z;
      3'b001:  cond_true = !z;
      3'b010:  cond_true = !n;
      3'b011:  cond_true = n;
      3'b100:  cond_true = !z && !n;
      3'b101:  cond_true = z || n;
      3'b110:  cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      opnd    <= '0;
      cond    <= '0;
      z       <= 1'b0;
      n       <= 1'b0;
      q       <= 1'b0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      // A drop in the same cycle as clr_err must leave err set.
      if (drop) begin
        err <= 1'b1;
      end else if (clr_err) begin
        err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (con_in) begin
            opnd  <= bus_contents;
            cond  <= ir[COND_LSB+2:COND_LSB];
            busy  <= 1'b1;
            state <= CAP;
          end
        end
        CAP: begin
          z     <= (opnd == '0);
          n     <= opnd[DATA_W-1];
          state <= EVAL;
        end
        EVAL: begin
          q       <= cond_true;
          q_valid <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CON_FF_UNIT_HISTORY_EN
  logic [7:0] hist_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg <= '0;
    end else if (state == EVAL) begin
      hist_reg <= {hist_reg[6:0], cond_true};
    end
  end

  assign hist = hist_reg;
`else
  assign hist = '0;
`endif

endmodule
